// File: rtl/awg_param_ctrl.sv
// Parameter controller and linear frequency-sweep scheduler for the sine generator.
// Register-style commands update en/freq/amp/phase in IDLE; SWEEP steps freq toward a target.
module awg_param_ctrl #(
  parameter logic [11:0] STEP     = 12'd1,
  parameter int unsigned DWELL    = 1000,
  parameter logic [11:0] FREQ_RST = 12'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [11:0] cmd_data,
  input  logic        abort,
  output logic        en,
  output logic [11:0] freq,
  output logic [2:0]  amp,
  output logic [7:0]  phase,
  output logic        busy,
  output logic        sweep_done,
  output logic        dbg_state
);

  // Handshake: a command transfers on a rising edge with cmd_valid && cmd_ready;
  // cmd_ready is high exactly while IDLE and does not depend on cmd_valid.

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  localparam logic [2:0] OP_SET_FREQ  = 3'd0;
  localparam logic [2:0] OP_SET_AMP   = 3'd1;
  localparam logic [2:0] OP_SET_PHASE = 3'd2;
  localparam logic [2:0] OP_SWEEP     = 3'd3;
  localparam logic [2:0] OP_ENABLE    = 3'd4;

  localparam logic [19:0] DWELL_M1 = 20'(DWELL - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [11:0] target_q, target_d;
  logic        up_q, up_d;
  logic [11:0] freq_q, freq_d;
  logic [2:0]  amp_q, amp_d;
  logic [7:0]  phase_q, phase_d;
  logic        en_q, en_d;
  logic        done_q, done_d;

  logic [12:0] step_up;
  logic [11:0] gap_dn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      up_q     <= 1'b0;
      freq_q   <= FREQ_RST;
      amp_q    <= 3'd1;
      phase_q  <= '0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      up_q     <= up_d;
      freq_q   <= freq_d;
      amp_q    <= amp_d;
      phase_q  <= phase_d;
      en_q     <= en_d;
      done_q   <= done_d;
    end
  end

  // Up-step is 13 bits wide so a step past 4095 is seen and clamped, not wrapped.
  assign step_up = {1'b0, freq_q} + {1'b0, STEP};
  assign gap_dn  = freq_q - target_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    up_d     = up_q;
    freq_d   = freq_q;
    amp_d    = amp_q;
    phase_d  = phase_q;
    en_d     = en_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_SET_FREQ:  freq_d  = cmd_data;
            OP_SET_AMP:   amp_d   = (cmd_data[2:0] == 3'd0) ? 3'd1 : cmd_data[2:0];
            OP_SET_PHASE: phase_d = cmd_data[7:0];
            OP_ENABLE:    en_d    = cmd_data[0];
            OP_SWEEP: begin
              target_d = cmd_data;
              up_d     = (cmd_data > freq_q);
              cnt_d    = DWELL_M1;
              state_d  = SWEEP;
            end
            default: ;
          endcase
        end
      end
      SWEEP: begin
        // Abort outranks completion: no done pulse when both land on one edge.
        if (abort) begin
          state_d = IDLE;
        end else if (freq_q == target_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          cnt_d = DWELL_M1;
          if (up_q) begin
            freq_d = (step_up >= {1'b0, target_q}) ? target_q : step_up[11:0];
          end else begin
            freq_d = (gap_dn <= STEP) ? target_q : (freq_q - STEP);
          end
        end else begin
          cnt_d = cnt_q - 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == SWEEP);
  assign sweep_done = done_q;
  assign en         = en_q;
  assign freq       = freq_q;
  assign amp        = amp_q;
  assign phase      = phase_q;
  assign dbg_state  = state_q;

endmodule
